dmem_ctrl: RTL

- Data-memory controller directly downstream of the load/store ALU memory port.
- Takes the ALU's word-aligned request (mem_req/addr/we/wdata plus byte enables) and decodes it to one of two targets: the on-chip synchronous data SRAM or the MMIO peripheral port.
- Guarantees exactly one target access per request, even though the ALU holds mem_req for two cycles.
- Returns read data and error in the cycle after the request rises, and captures the first faulting address for the trap logic.

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmem_ctrl_if.sv | 55 +++++
 rtl/dmem_ctrl_addr_decode.sv | 39 +++
 rtl/dmem_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared configuration for the data-memory controller: widths, memory map and
// the region encoding produced by the address decoder.
package dmem_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    localparam logic [XLEN-1:0] DMEM_BASE  = 32'h1000_0000;
    localparam int unsigned     DMEM_WORDS = 4096;
    localparam int              DMEM_AW    = $clog2(DMEM_WORDS);
    localparam logic [XLEN-1:0] DMEM_BYTES = XLEN'(DMEM_WORDS * 4);

    localparam logic [XLEN-1:0] MMIO_BASE  = 32'h2000_0000;
    localparam logic [XLEN-1:0] MMIO_BYTES = 32'h0000_1000;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DMEM,
        REG_MMIO
    } mem_region_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundles the ALU request port, the SRAM and MMIO target ports and the fault
// reporting signals of the data-memory controller.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                 mem_req;
    logic [XLEN-1:0]      mem_addr;
    logic                 mem_we;
    logic [BE_W-1:0]      mem_be;
    logic [XLEN-1:0]      mem_wdata;
    logic [XLEN-1:0]      mem_rdata;
    logic                 mem_err;

    logic                 sram_en;
    logic                 sram_we;
    logic [BE_W-1:0]      sram_be;
    logic [DMEM_AW-1:0]   sram_addr;
    logic [XLEN-1:0]      sram_wdata;
    logic [XLEN-1:0]      sram_rdata;

    logic                 mmio_req;
    logic                 mmio_we;
    logic [BE_W-1:0]      mmio_be;
    logic [XLEN-1:0]      mmio_addr;
    logic [XLEN-1:0]      mmio_wdata;
    logic [XLEN-1:0]      mmio_rdata;
    logic                 mmio_err;

    logic                 fault_valid;
    logic [XLEN-1:0]      fault_addr;
    logic                 fault_clear;

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata, mem_err,
        output sram_en, sram_we, sram_be, sram_addr, sram_wdata,
        input  sram_rdata,
        output mmio_req, mmio_we, mmio_be, mmio_addr, mmio_wdata,
        input  mmio_rdata, mmio_err,
        output fault_valid, fault_addr,
        input  fault_clear
    );

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata, mem_err,
        input  sram_en, sram_we, sram_be, sram_addr, sram_wdata,
        output sram_rdata,
        input  mmio_req, mmio_we, mmio_be, mmio_addr, mmio_wdata,
        output mmio_rdata, mmio_err,
        input  fault_valid, fault_addr,
        output fault_clear
    );

endinterface

// File: rtl/dmem_ctrl_addr_decode.sv
// Combinational address decoder: classifies a word access as DMEM, MMIO or
// unmapped and reports the byte offset within the hit region.
module dmem_addr_decode
    import dmem_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] addr_i,
    input  logic [BE_W-1:0] be_i,
    output mem_region_t     region_o,
    output logic            error_o,
    output logic [XLEN-1:0] offset_o
);

    logic [XLEN-1:0] dmem_off;
    logic [XLEN-1:0] mmio_off;
    logic            in_dmem;
    logic            in_mmio;

    // Lower bound checked explicitly, then the offset against the span, so an
    // address just below a base can never wrap into a hit.
    assign dmem_off = addr_i - DMEM_BASE;
    assign mmio_off = addr_i - MMIO_BASE;
    assign in_dmem  = (addr_i >= DMEM_BASE) && (dmem_off < DMEM_BYTES);
    assign in_mmio  = (addr_i >= MMIO_BASE) && (mmio_off < MMIO_BYTES);

    always_comb begin
        region_o = REG_NONE;
        offset_o = '0;
        if (in_dmem) begin
            region_o = REG_DMEM;
            offset_o = dmem_off;
        end else if (in_mmio) begin
            region_o = REG_MMIO;
            offset_o = mmio_off;
        end
    end

    assign error_o = (region_o == REG_NONE) || (addr_i[1:0] != 2'b00) || (be_i == '0);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: issues exactly one SRAM or MMIO strobe per ALU
// request, returns data/error one cycle later and records the first fault.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RESP = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    mem_region_t     dec_region, region_q;
    logic            dec_err, err_q, we_q;
    logic [XLEN-1:0] dec_off, addr_q;
    logic            fault_valid_q;
    logic [XLEN-1:0] fault_addr_q;
    logic            start, resp, sram_hit, mmio_hit;

    dmem_addr_decode u_decode (
        .addr_i   (bus.mem_addr),
        .be_i     (bus.mem_be),
        .region_o (dec_region),
        .error_o  (dec_err),
        .offset_o (dec_off)
    );

    // rst_n gates the strobes so a request held across reset cannot leak one.
    assign start    = rst_n && (state_q == IDLE) && bus.mem_req;
    assign resp     = rst_n && (state_q == RESP);
    assign sram_hit = start && !dec_err && (dec_region == REG_DMEM);
    assign mmio_hit = start && !dec_err && (dec_region == REG_MMIO);

    always_comb begin
        bus.sram_en    = sram_hit;
        bus.sram_we    = sram_hit && bus.mem_we;
        bus.sram_be    = sram_hit ? bus.mem_be : '0;
        bus.sram_addr  = sram_hit ? dec_off[DMEM_AW+1:2] : '0;
        bus.sram_wdata = sram_hit ? bus.mem_wdata : '0;
        bus.mmio_req   = mmio_hit;
        bus.mmio_we    = mmio_hit && bus.mem_we;
        bus.mmio_be    = mmio_hit ? bus.mem_be : '0;
        bus.mmio_addr  = mmio_hit ? dec_off : '0;
        bus.mmio_wdata = mmio_hit ? bus.mem_wdata : '0;
    end

    always_comb begin
        bus.mem_rdata = '0;
        bus.mem_err   = 1'b0;
        if (resp) begin
            bus.mem_err = err_q || ((region_q == REG_MMIO) && bus.mmio_err);
            if (!err_q && !we_q) begin
                if (region_q == REG_DMEM) begin
                    bus.mem_rdata = bus.sram_rdata;
                end else if (region_q == REG_MMIO) begin
                    bus.mem_rdata = bus.mmio_rdata;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.mem_req) state_d = RESP;
            RESP:    state_d = bus.mem_req ? HOLD : IDLE;
            HOLD:    if (!bus.mem_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            region_q <= REG_NONE;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                region_q <= dec_region;
                err_q    <= dec_err;
                we_q     <= bus.mem_we;
                addr_q   <= bus.mem_addr;
            end
        end
    end

    // A clear coinciding with a new fault still lets that fault be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else if (resp && bus.mem_err && (!fault_valid_q || bus.fault_clear)) begin
            fault_valid_q <= 1'b1;
            fault_addr_q  <= addr_q;
        end else if (bus.fault_clear) begin
            fault_valid_q <= 1'b0;
        end
    end

    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_addr  = fault_addr_q;

endmodule
